program_loader: RTL and testbench

//  Sequences a program image into the mini-computer RAM through the halt-mode load port of cpu_top.

---
 rtl/loader_pkg.sv | 24 ++
 rtl/program_loader_if.sv | 30 +++
 rtl/cycle_timer.sv | 24 ++
 rtl/program_loader.sv | 156 +++++++++++++++
 tb/tb_program_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared state encoding and timing defaults for the program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWait,
        StWrite,
        StNext,
        StRelease,
        StFinish
    } state_e;

    localparam int unsigned DefWriteCycles = 2;
    localparam int unsigned DefRstCycles   = 2;

    // Timer holds (cycles - 1), so it only needs to represent max(a, b) - 1.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host-side request/byte stream and CPU halt-mode load port of the program loader.
interface program_loader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              abort;
    logic [DATA_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              halt;
    logic              new_in;
    logic [ADDR_W-1:0] program_addr;
    logic [DATA_W-1:0] program_data;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output load_start, load_len, abort, byte_in, byte_valid,
        input  byte_ready, halt, new_in, program_addr, program_data, cpu_rst, busy, done, err
    );

    modport slave (
        input  load_start, load_len, abort, byte_in, byte_valid,
        output byte_ready, halt, new_in, program_addr, program_data, cpu_rst, busy, done, err
    );
endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired is high once the count has reached zero.
module cycle_timer #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);
    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);
endmodule

// File: rtl/program_loader.sv
// Streams a program image into CPU RAM through the halt-mode load port, then restarts the CPU.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned WRITE_CYCLES = DefWriteCycles,
    parameter int unsigned RST_CYCLES   = DefRstCycles
) (
    input logic             clk,
    input logic             rst,
    program_loader_if.slave bus
);
    localparam int unsigned       TimerW    = timer_width(WRITE_CYCLES, RST_CYCLES);
    localparam logic [TimerW-1:0] WriteLoad = TimerW'(WRITE_CYCLES - 1);
    localparam logic [TimerW-1:0] RelLoad   = TimerW'(RST_CYCLES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, count_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              abort_pend_q, abort_pend_d;
    logic              err_q, err_set;
    logic              halt_q, new_in_q, ready_q, cpu_rst_q, busy_q, done_q;
    logic              xfer, timer_load, timer_expired;
    logic [TimerW-1:0] timer_val;

    // abort masks the handshake so a byte offered alongside an abort is never taken.
    assign xfer = bus.byte_valid & ready_q & ~bus.abort;

    cycle_timer #(
        .WIDTH (TimerW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        abort_pend_d = abort_pend_q;
        err_set      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.load_start) state_d = StArm;
            end
            StArm: begin
                if (bus.abort) begin
                    state_d = StRelease;
                    err_set = 1'b1;
                end else if (len_q == '0) begin
                    state_d = StRelease;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.abort) begin
                    state_d = StRelease;
                    err_set = 1'b1;
                end else if (xfer) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // An abort here is deferred until the write window has fully elapsed.
                if (timer_expired) begin
                    if (abort_pend_q || bus.abort) begin
                        state_d = StRelease;
                        err_set = 1'b1;
                    end else begin
                        state_d = StNext;
                    end
                end else if (bus.abort) begin
                    abort_pend_d = 1'b1;
                end
            end
            StNext: begin
                if (bus.abort) begin
                    state_d = StRelease;
                    err_set = 1'b1;
                end else if (count_q == len_q) begin
                    state_d = StRelease;
                end else begin
                    state_d = StWait;
                end
            end
            StRelease: begin
                if (timer_expired) state_d = StFinish;
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d != StWrite) abort_pend_d = 1'b0;
        timer_load = (state_d != state_q) && (state_d == StWrite || state_d == StRelease);
        timer_val  = (state_d == StWrite) ? WriteLoad : RelLoad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            len_q        <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            abort_pend_q <= 1'b0;
            err_q        <= 1'b0;
            halt_q       <= 1'b0;
            new_in_q     <= 1'b0;
            ready_q      <= 1'b0;
            cpu_rst_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            abort_pend_q <= abort_pend_d;
            if (state_q == StIdle && bus.load_start) begin
                len_q   <= bus.load_len;
                count_q <= '0;
                addr_q  <= '0;
                err_q   <= 1'b0;
            end
            if (state_q == StWait && xfer) data_q <= bus.byte_in;
            if (state_q == StWrite && state_d == StNext) begin
                addr_q  <= addr_q + 1'b1;
                count_q <= count_q + 1'b1;
            end
            if (err_set) err_q <= 1'b1;

            // Outputs are decoded from the next state so they are glitch-free registers.
            halt_q    <= state_d inside {StArm, StWait, StWrite, StNext, StRelease};
            new_in_q  <= state_d inside {StArm, StWait, StNext, StRelease};
            ready_q   <= (state_d == StWait);
            cpu_rst_q <= (state_d == StRelease);
            busy_q    <= (state_d != StIdle);
            done_q    <= (state_d == StFinish);
        end
    end

    assign bus.byte_ready   = ready_q & ~bus.abort;
    assign bus.halt         = halt_q;
    assign bus.new_in       = new_in_q;
    assign bus.program_addr = addr_q;
    assign bus.program_data = data_q;
    assign bus.cpu_rst      = cpu_rst_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a RAM-level model of the CPU load port.
module tb_program_loader;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int WC = 2;
    localparam int RC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    program_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    program_loader #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .WRITE_CYCLES (WC),
        .RST_CYCLES   (RC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // CPU-side RAM: MAR latches on halt&new_in, RAM written on halt&~new_in.
    logic [7:0] ram     [256];
    logic [7:0] exp_ram [256];
    logic [7:0] mar;
    logic [7:0] src     [512];

    int         obs_cycles, obs_busy, obs_windows, obs_wr_cycles, obs_rst_cycles;
    int         obs_accepted, obs_torn;
    bit         obs_done, obs_rst_hit;
    logic       obs_halt_done, obs_cpu_rst_done, obs_err_done, obs_ready_abort;
    logic       obs_rst_halt, obs_rst_new_in;
    logic [7:0] obs_addr_done;

    function automatic int ram_diffs();
        int bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) bad++;
        return bad;
    endfunction

    task automatic expect_bytes(input int n);
        for (int i = 0; i < n; i++) exp_ram[i % 256] = src[i];
    endtask

    // Runs one load; abort_win>0 aborts in that write window, abort_acc>=0 aborts in the WAIT
    // for that byte index, rst_acc>=0 resets in the WAIT for that byte index.
    task automatic do_load(input int len, input int valid_pct, input int abort_win,
                           input int abort_acc, input int rst_acc);
        bit         prev_wr, aborted, ab_now;
        logic [7:0] wr_addr, wr_data;
        int         idx;
        obs_cycles = 0; obs_busy = 0; obs_windows = 0; obs_wr_cycles = 0; obs_rst_cycles = 0;
        obs_accepted = 0; obs_torn = 0; obs_done = 0; obs_rst_hit = 0; obs_ready_abort = 1'b1;
        obs_halt_done = 1'bx; obs_cpu_rst_done = 1'bx; obs_err_done = 1'bx;
        obs_addr_done = 8'hxx;
        prev_wr = 0; aborted = 0; idx = 0; wr_addr = 0; wr_data = 0;
        @(negedge clk);
        bus.load_len   = 9'(len);
        bus.load_start = 1'b1;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            bus.load_start = 1'b0;
            bus.abort      = 1'b0;
            bus.byte_valid = 1'b0;
            ab_now         = 0;
            #1;
            obs_cycles = cyc;
            if (bus.busy) obs_busy++;
            if (bus.cpu_rst) obs_rst_cycles++;
            if (bus.halt && bus.new_in) mar = bus.program_addr;
            if (bus.halt && !bus.new_in) begin
                ram[mar] = bus.program_data;
                obs_wr_cycles++;
                if (!prev_wr) begin
                    obs_windows++;
                    wr_addr = bus.program_addr;
                    wr_data = bus.program_data;
                end else if (wr_addr !== bus.program_addr || wr_data !== bus.program_data) begin
                    obs_torn++;
                end
            end
            prev_wr = bus.halt && !bus.new_in;
            if (bus.done) begin
                obs_done         = 1;
                obs_halt_done    = bus.halt;
                obs_cpu_rst_done = bus.cpu_rst;
                obs_err_done     = bus.err;
                obs_addr_done    = bus.program_addr;
                break;
            end
            bus.byte_in    = src[idx];
            bus.byte_valid = ($urandom_range(99) < valid_pct);
            // Stray load requests while busy must be ignored.
            bus.load_start = ($urandom_range(7) == 0);
            bus.load_len   = 9'($urandom);
            if (abort_win > 0 && !aborted && prev_wr && obs_windows == abort_win) begin
                bus.abort = 1'b1;
                aborted   = 1;
            end
            if (abort_acc >= 0 && !aborted && bus.byte_ready && idx == abort_acc) begin
                bus.abort      = 1'b1;
                bus.byte_valid = 1'b1;
                aborted        = 1;
                ab_now         = 1;
            end
            if (rst_acc >= 0 && bus.byte_ready && idx == rst_acc) begin
                rst            = 1'b1;
                bus.byte_valid = 1'b1;
                @(negedge clk);
                #1;
                obs_rst_hit    = 1;
                obs_rst_halt   = bus.halt;
                obs_rst_new_in = bus.new_in;
                rst            = 1'b0;
                bus.load_start = 1'b0;
                break;
            end
            #1;
            if (ab_now) obs_ready_abort = bus.byte_ready;
            if (bus.byte_valid && bus.byte_ready) begin
                idx++;
                obs_accepted++;
            end
        end
        bus.load_start = 1'b0;
        bus.abort      = 1'b0;
        bus.byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus.halt, bus.new_in, bus.cpu_rst, bus.busy, bus.done, bus.err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, want 000000",
                     {bus.halt, bus.new_in, bus.cpu_rst, bus.busy, bus.done, bus.err});
        end
        checks++;
        if (bus.byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b, want 0", bus.byte_ready);
        end
        checks++;
        if ({bus.program_addr, bus.program_data} !== 16'h0) begin
            failures++;
            $display("FAIL reset_bus: got %h, want 0000", {bus.program_addr, bus.program_data});
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy got %b, want 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        int exp_cyc;
        src[0] = 8'hA5; src[1] = 8'h3C; src[2] = 8'hFF;
        exp_ram = ram;
        expect_bytes(3);
        exp_cyc = 1 + 3 * (WC + 2) + RC + 1;
        do_load(3, 100, 0, -1, -1);
        checks++;
        if (obs_done !== 1'b1) begin failures++; $display("FAIL basic_done: got %0d, want 1", obs_done); end
        checks++;
        if (obs_cycles !== exp_cyc) begin
            failures++; $display("FAIL basic_cycles: got %0d, want %0d", obs_cycles, exp_cyc);
        end
        checks++;
        if (obs_busy !== exp_cyc) begin
            failures++; $display("FAIL basic_busy: got %0d, want %0d", obs_busy, exp_cyc);
        end
        checks++;
        if (obs_windows !== 3 || obs_wr_cycles !== 3 * WC) begin
            failures++;
            $display("FAIL basic_writes: got %0d windows/%0d cycles, want 3/%0d",
                     obs_windows, obs_wr_cycles, 3 * WC);
        end
        checks++;
        if (ram_diffs() !== 0) begin failures++; $display("FAIL basic_ram: got %0d bad, want 0", ram_diffs()); end
        checks++;
        if (obs_rst_cycles !== RC) begin
            failures++; $display("FAIL basic_cpu_rst: got %0d, want %0d", obs_rst_cycles, RC);
        end
        checks++;
        if ({obs_halt_done, obs_cpu_rst_done, obs_err_done} !== 3'b000) begin
            failures++;
            $display("FAIL basic_finish: got %b, want 000", {obs_halt_done, obs_cpu_rst_done, obs_err_done});
        end
        checks++;
        if (obs_torn !== 0) begin failures++; $display("FAIL basic_stable: got %0d, want 0", obs_torn); end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            failures++; $display("FAIL basic_pulse: done,busy got %b, want 00", {bus.done, bus.busy});
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 256; i++) src[i] = 8'(i);
        exp_ram = ram;
        expect_bytes(256);
        do_load(256, 70, 0, -1, -1);
        checks++;
        if (obs_done !== 1'b1 || obs_accepted !== 256) begin
            failures++; $display("FAIL full_done: got done=%0d n=%0d, want 1/256", obs_done, obs_accepted);
        end
        checks++;
        if (obs_windows !== 256) begin failures++; $display("FAIL full_windows: got %0d, want 256", obs_windows); end
        checks++;
        if (ram_diffs() !== 0) begin failures++; $display("FAIL full_ram: got %0d bad, want 0", ram_diffs()); end
        checks++;
        if (obs_addr_done !== 8'h00) begin
            failures++; $display("FAIL full_addr_wrap: got %h, want 00", obs_addr_done);
        end
        checks++;
        if (obs_err_done !== 1'b0 || obs_torn !== 0) begin
            failures++; $display("FAIL full_err: got err=%b torn=%0d, want 0/0", obs_err_done, obs_torn);
        end
    endtask

    task automatic test_zero_len();
        exp_ram = ram;
        do_load(0, 100, 0, -1, -1);
        checks++;
        if (obs_done !== 1'b1 || obs_busy !== 4 || obs_cycles !== 4) begin
            failures++;
            $display("FAIL zero_busy: got done=%0d busy=%0d cyc=%0d, want 1/4/4",
                     obs_done, obs_busy, obs_cycles);
        end
        checks++;
        if (obs_wr_cycles !== 0 || obs_accepted !== 0) begin
            failures++;
            $display("FAIL zero_nowrite: got wr=%0d acc=%0d, want 0/0", obs_wr_cycles, obs_accepted);
        end
        checks++;
        if (obs_rst_cycles !== RC) begin
            failures++; $display("FAIL zero_cpu_rst: got %0d, want %0d", obs_rst_cycles, RC);
        end
        checks++;
        if (ram_diffs() !== 0) begin failures++; $display("FAIL zero_ram: got %0d bad, want 0", ram_diffs()); end
    endtask

    task automatic test_abort_write();
        for (int i = 0; i < 4; i++) src[i] = 8'($urandom);
        exp_ram = ram;
        expect_bytes(2);
        do_load(4, 100, 2, -1, -1);
        checks++;
        if (obs_accepted !== 2 || obs_windows !== 2 || obs_wr_cycles !== 2 * WC) begin
            failures++;
            $display("FAIL abortw_count: got acc=%0d win=%0d wr=%0d, want 2/2/%0d",
                     obs_accepted, obs_windows, obs_wr_cycles, 2 * WC);
        end
        checks++;
        if (ram_diffs() !== 0) begin failures++; $display("FAIL abortw_ram: got %0d bad, want 0", ram_diffs()); end
        checks++;
        if (obs_done !== 1'b1 || obs_err_done !== 1'b1 || obs_halt_done !== 1'b0) begin
            failures++;
            $display("FAIL abortw_end: got done=%0d err=%b halt=%b, want 1/1/0",
                     obs_done, obs_err_done, obs_halt_done);
        end
        checks++;
        if (obs_rst_cycles !== RC) begin
            failures++; $display("FAIL abortw_cpu_rst: got %0d, want %0d", obs_rst_cycles, RC);
        end
    endtask

    task automatic test_abort_wait();
        for (int i = 0; i < 4; i++) src[i] = 8'($urandom);
        exp_ram = ram;
        expect_bytes(1);
        do_load(4, 100, 0, 1, -1);
        checks++;
        if (obs_ready_abort !== 1'b0 || obs_accepted !== 1) begin
            failures++;
            $display("FAIL abortv_ready: got ready=%b acc=%0d, want 0/1", obs_ready_abort, obs_accepted);
        end
        checks++;
        if (obs_err_done !== 1'b1 || ram_diffs() !== 0) begin
            failures++;
            $display("FAIL abortv_end: got err=%b bad=%0d, want 1/0", obs_err_done, ram_diffs());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) src[i] = 8'($urandom);
        exp_ram = ram;
        expect_bytes(5);
        do_load(5, 50, 0, -1, -1);
        checks++;
        if (obs_done !== 1'b1 || obs_err_done !== 1'b0 || ram_diffs() !== 0) begin
            failures++;
            $display("FAIL b2b_load: got done=%0d err=%b bad=%0d, want 1/0/0",
                     obs_done, obs_err_done, ram_diffs());
        end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 8; i++) src[i] = 8'($urandom);
        do_load(8, 100, 0, -1, 4);
        checks++;
        if (obs_rst_hit !== 1'b1 || {obs_rst_halt, obs_rst_new_in} !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_drop: got hit=%0d halt,new_in=%b, want 1/00",
                     obs_rst_hit, {obs_rst_halt, obs_rst_new_in});
        end
        for (int i = 0; i < 3; i++) src[i] = 8'($urandom);
        exp_ram = ram;
        expect_bytes(3);
        do_load(3, 100, 0, -1, -1);
        checks++;
        if (obs_done !== 1'b1 || obs_err_done !== 1'b0 || ram_diffs() !== 0) begin
            failures++;
            $display("FAIL rstmid_reload: got done=%0d err=%b bad=%0d, want 1/0/0",
                     obs_done, obs_err_done, ram_diffs());
        end
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.load_len   = '0;
        bus.abort      = 1'b0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        mar            = 8'h00;
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_full();
        test_zero_len();
        test_abort_write();
        test_abort_wait();
        test_back_to_back();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
